sha256: RTL and testbench
=========================

// Module: sha256
// PURPOSE
//  Byte-serial SHA-256 hasher. Accepts a 1..128-byte message one byte per clock, pads it
//  per FIPS 180-4, runs the compression over 1-3 blocks and presents the 256-bit digest.
//  Sits between a byte source (e.g. file or UART reader) and a digest consumer.
// PARAMETERS
//  MAX_BYTES  128  maximum message length in bytes; buffer and length counter sized from it
// PORTS
//  clk         in   1    single clock, rising-edge
//  rst         in   1    asynchronous, active-high reset
//  start       in   1    begin new message: clears buffer, length, digest, done
//  data_valid  in   1    in carries a message byte this cycle
//  in          in   8    message byte, first byte first (big-endian into words)
//  result      out  256  digest H0..H7, H0 in [255:224]
//  done        out  1    digest valid; level, held until rst or start
// BEHAVIOUR
//  - Reset (async): result=0, done=0, length=0, state IDLE, H regs = IV.
//  - start=1 on an edge: length<=0, done<=0, H<=IV, buffer cleared, state LOAD.
//    If data_valid=1 in that same cycle, that byte is stored at index 0 (length<=1).
//  - LOAD: each edge with data_valid=1 stores in at buffer[length], length++.
//    Bytes beyond MAX_BYTES are ignored. First edge with data_valid=0 after >=1 byte -> PAD.
//    data_valid=0 with length=0 stays in LOAD.
//  - PAD (1 cycle): append 0x80 after the last byte, zero fill, 64-bit bit-length (len*8)
//    in the last 8 bytes of the final block. nblk = ceil((len+9)/64): 1..55->1, 56..119->2,
//    120..128->3. Then BLK.
//  - BLK (1 cycle): a..h <= H0..H7; load W[0..15] of current block into a 16-word window.
//  - ROUND (64 cycles, t=0..63): one compression round per cycle with K[t]; W[t>=16] from
//    the sliding window (sigma0/sigma1 of window taps). All arithmetic mod 2^32.
//  - UPD (1 cycle): Hi <= Hi + {a..h}. If more blocks -> BLK of next block, else DONE.
//  - DONE: result <= {H0..H7}; done<=1 and held; inputs ignored except start/rst.
//  - Latency: done rises 1 + 66*nblk cycles after the first data_valid=0 edge
//    (67 / 133 / 199 cycles).
//  - result changes only on entering DONE, on start (->0) or reset (->0).
//  - rst or start mid-load or mid-compression aborts cleanly; no stale state leaks
//    into the next digest.
// STRUCTURE
//  - Package sha256_pkg: K[0:63] constant table, IV H0..H7, state enum
//    (IDLE,LOAD,PAD,BLK,ROUND,UPD,DONE), functions ch, maj, Sigma0/1, sigma0/1.
//  - One sub-module sha256_round: combinational round (a..h, Kt, Wt -> next a..h).
//    Top keeps the FSM, byte buffer, padding, W window and H regs.
// TESTING
//  - "abc" (3 bytes) -> done after 67 cycles,
//    result=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
//  - "a" -> result=ca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb.
//  - "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (56 bytes, 2 blocks)
//    -> result=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
//  - Length boundaries 55/56/64/119/120/128 bytes of printable text -> match software
//    SHA-256 model; done latency 67/133/133/133/199/199.
//  - Back-to-back: after done, rst pulse + start, hash "abc" then "a"
//    -> each digest correct, done low between messages.
//  - rst asserted during ROUND of a 2-block message -> result=0, done=0 immediately;
//    following "abc" gives the correct digest.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 constants, FSM encodings and bit-mixing functions
package sha256_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_PAD   = 3'd2;
  localparam logic [2:0] ST_BLK   = 3'd3;
  localparam logic [2:0] ST_ROUND = 3'd4;
  localparam logic [2:0] ST_UPD   = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round over working vars a..h
module sha256_round
  import sha256_pkg::*;
(
  input  logic [0:7][31:0] v_i,
  input  logic [31:0]      k_i,
  input  logic [31:0]      w_i,
  output logic [0:7][31:0] v_o
);
  logic [31:0] t1;
  logic [31:0] t2;
  assign t1  = v_i[7] + big_sigma1(v_i[4]) + ch(v_i[4], v_i[5], v_i[6]) + k_i + w_i;
  assign t2  = big_sigma0(v_i[0]) + maj(v_i[0], v_i[1], v_i[2]);
  assign v_o = {t1 + t2, v_i[0], v_i[1], v_i[2], v_i[3] + t1, v_i[4], v_i[5], v_i[6]};
endmodule

// File: rtl/sha256.sv
// sha256: byte-serial SHA-256 hasher with in-buffer padding for 1..MAX_BYTES byte messages
module sha256
  import sha256_pkg::*;
#(
  parameter int MAX_BYTES = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         data_valid,
  input  logic [7:0]   in,
  output logic [255:0] result,
  output logic         done
);
  localparam int NBLK_MAX = (MAX_BYTES + 72) / 64;
  localparam int BYTES = NBLK_MAX * 64;
  localparam int LW = $clog2(MAX_BYTES + 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_BYTES);

  logic [2:0]       state_q, state_d;
  logic [LW-1:0]    len_q;
  logic [7:0]       buf_q [BYTES];
  logic [1:0]       nblk_q, blk_q, nblk_w;
  logic [5:0]       t_q;
  logic [0:7][31:0] h_q, v_q, v_nx, h_sum;
  logic [0:15][31:0] w_q, blk_w;
  logic [31:0]      w_new;
  logic [255:0]     result_q;
  logic             done_q, last_blk;
  logic [15:0]      len16, endp, bitlen;

  assign result   = result_q;
  assign done     = done_q;
  assign len16    = 16'(len_q);
  assign bitlen   = 16'({len_q, 3'b000});
  assign endp     = 16'(nblk_q) * 16'd64;
  assign nblk_w   = 2'((len16 + 16'd72) >> 6);
  assign last_blk = (blk_q + 2'd1) == nblk_q;
  assign w_new    = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];

  for (genvar j = 0; j < 16; j++) begin : g_blk
    assign blk_w[j] = {buf_q[{blk_q, 6'(4*j)}], buf_q[{blk_q, 6'(4*j+1)}],
                       buf_q[{blk_q, 6'(4*j+2)}], buf_q[{blk_q, 6'(4*j+3)}]};
  end

  for (genvar j = 0; j < 8; j++) begin : g_sum
    assign h_sum[j] = h_q[j] + v_q[j];
  end

  sha256_round u_round (
    .v_i(v_q),
    .k_i(K[t_q]),
    .w_i(w_q[0]),
    .v_o(v_nx)
  );

  // next-state: start always restarts loading, otherwise walk PAD/BLK/ROUND/UPD per block
  always_comb begin
    state_d = start ? ST_LOAD :
              state_q == ST_LOAD  ? ((!data_valid && len_q != '0) ? ST_PAD : ST_LOAD) :
              state_q == ST_PAD   ? ST_BLK :
              state_q == ST_BLK   ? ST_ROUND :
              state_q == ST_ROUND ? (t_q == 6'd63 ? ST_UPD : ST_ROUND) :
              state_q == ST_UPD   ? (last_blk ? ST_DONE : ST_BLK) : state_q;
  end

  // datapath: byte capture, in-place padding, message window, compression and digest update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      for (int i = 0; i < BYTES; i++) buf_q[i] <= 8'h00;
      nblk_q   <= '0;
      blk_q    <= '0;
      t_q      <= '0;
      h_q      <= IV;
      v_q      <= '0;
      w_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        for (int i = 0; i < BYTES; i++) buf_q[i] <= 8'h00;
        if (data_valid) buf_q[0] <= in;
        len_q    <= data_valid ? LW'(1) : '0;
        blk_q    <= '0;
        h_q      <= IV;
        result_q <= '0;
        done_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_LOAD: begin
            if (data_valid && len_q < LEN_MAX) begin
              buf_q[len_q] <= in;
              len_q        <= len_q + 1'b1;
            end
            nblk_q <= nblk_w;
            blk_q  <= '0;
          end
          ST_PAD: begin
            for (int i = 0; i < BYTES; i++)
              buf_q[i] <= 16'(i) <  len16          ? buf_q[i] :
                          16'(i) == len16          ? 8'h80 :
                          16'(i) == endp - 16'd1   ? bitlen[7:0] :
                          16'(i) == endp - 16'd2   ? bitlen[15:8] : 8'h00;
          end
          ST_BLK: begin
            v_q <= h_q;
            w_q <= blk_w;
            t_q <= '0;
          end
          ST_ROUND: begin
            v_q <= v_nx;
            w_q <= {w_q[1:15], w_new};
            t_q <= t_q + 6'd1;
          end
          ST_UPD: begin
            h_q   <= h_sum;
            blk_q <= blk_q + 2'd1;
            if (last_blk) begin
              result_q <= h_sum;
              done_q   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sha256.sv
// tb_sha256: scoreboard bench for the byte-serial SHA-256 hasher
module tb_sha256;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         data_valid = 1'b0;
  logic [7:0]   in = 8'h00;
  logic [255:0] result;
  logic         done;

  typedef struct {
    logic [255:0] dig;
    int           lat;
    int           e0;
    int           id;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] msg [128];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         nid = 0;

  localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_A   = 256'hca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb;
  localparam logic [255:0] D_56  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam string S56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";

  sha256 dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .data_valid(data_valid),
    .in(in),
    .result(result),
    .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [255:0] ref_sha(input logic [7:0] m [128], input int n);
    logic [7:0]  p [192];
    logic [31:0] w [64];
    logic [31:0] hv [8];
    logic [31:0] s [8];
    logic [31:0] t1, t2;
    logic [63:0] bits;
    int nb;
    nb = (n + 9 + 63) / 64;
    bits = 64'(n) * 64'd8;
    for (int i = 0; i < 192; i++) begin
      if (i < n) p[i] = m[i];
      else p[i] = (i == n) ? 8'h80 : 8'h00;
    end
    for (int i = 0; i < 8; i++) p[nb*64-1-i] = bits[8*i +: 8];
    hv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int bk = 0; bk < nb; bk++) begin
      for (int t = 0; t < 16; t++)
        w[t] = {p[bk*64+4*t], p[bk*64+4*t+1], p[bk*64+4*t+2], p[bk*64+4*t+3]};
      for (int t = 16; t < 64; t++)
        w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7] +
               (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      for (int k = 0; k < 8; k++) s[k] = hv[k];
      for (int t = 0; t < 64; t++) begin
        t1 = s[7] + (rr(s[4], 6) ^ rr(s[4], 11) ^ rr(s[4], 25)) +
             ((s[4] & s[5]) ^ (~s[4] & s[6])) + sha256_pkg::K[t] + w[t];
        t2 = (rr(s[0], 2) ^ rr(s[0], 13) ^ rr(s[0], 22)) +
             ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
        for (int k = 7; k > 0; k--) s[k] = s[k-1];
        s[4] = s[4] + t1;
        s[0] = t1 + t2;
      end
      for (int k = 0; k < 8; k++) hv[k] = hv[k] + s[k];
    end
    return {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
  endfunction

  task automatic set_str(input string str);
    for (int i = 0; i < str.len(); i++) msg[i] = str[i];
  endtask

  task automatic send(input int n, input bit chk, input logic [255:0] dig);
    exp_t e;
    @(negedge clk);
    start = 1'b1; data_valid = 1'b1; in = msg[0];
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      start = 1'b0; in = msg[i];
    end
    @(negedge clk);
    start = 1'b0; data_valid = 1'b0; in = 8'h00;
    @(posedge clk); #1;
    nid++;
    total++;
    if (done !== 1'b0) begin
      $display("FAIL done_low msg%0d got=%b want=0", nid, done);
      bad++;
    end
    if (chk) begin
      e.dig = dig;
      e.lat = 1 + 66 * ((n + 72) / 64);
      e.e0  = cyc;
      e.id  = nid;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done !== 1'b1 && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    total++;
    if (done !== 1'b1) begin
      $display("FAIL done_timeout msg%0d got=%b want=1", nid, done);
      bad++;
    end
    @(negedge clk);
  endtask

  task automatic check_cleared(input string nm);
    total += 2;
    if (result !== 256'h0) begin
      $display("FAIL %s result got=%h want=0", nm, result);
      bad++;
    end
    if (done !== 1'b0) begin
      $display("FAIL %s done got=%b want=0", nm, done);
      bad++;
    end
  endtask

  // monitor: pop an expectation on each done rising edge and compare digest and latency
  initial begin
    exp_t e;
    bit prev;
    prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (done === 1'b1 && !prev) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done got=1 want=no digest pending");
        end else begin
          e = sb.pop_front();
          total += 2;
          if (result !== e.dig) begin
            $display("FAIL digest msg%0d got=%h want=%h", e.id, result, e.dig);
            bad++;
          end
          if (cyc - e.e0 != e.lat) begin
            $display("FAIL latency msg%0d got=%0d want=%0d", e.id, cyc - e.e0, e.lat);
            bad++;
          end
        end
      end
      prev = (done === 1'b1);
    end
  end

  initial begin
    int lens [6] = '{55, 56, 64, 119, 120, 128};
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b0;
    set_str("abc");
    send(3, 1'b1, D_ABC);
    wait_done();
    set_str("a");
    send(1, 1'b1, D_A);
    wait_done();
    set_str(S56);
    send(56, 1'b1, D_56);
    wait_done();
    for (int li = 0; li < 6; li++) begin
      for (int i = 0; i < 128; i++) msg[i] = 8'h20 + 8'((i * 7 + 3 + li) % 95);
      send(lens[li], 1'b1, ref_sha(msg, lens[li]));
      wait_done();
    end
    #3 rst = 1'b1;
    #1 check_cleared("rst_after_done");
    @(negedge clk);
    rst = 1'b0;
    set_str("abc");
    send(3, 1'b1, D_ABC);
    wait_done();
    set_str("a");
    send(1, 1'b1, D_A);
    wait_done();
    set_str(S56);
    send(56, 1'b0, '0);
    repeat (40) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_cleared("rst_mid_round");
    @(negedge clk);
    rst = 1'b0;
    set_str("abc");
    send(3, 1'b1, D_ABC);
    wait_done();
    set_str("zzzzzzzzzz");
    @(negedge clk);
    start = 1'b1; data_valid = 1'b1; in = msg[0];
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      start = 1'b0; in = msg[i];
    end
    set_str("abc");
    send(3, 1'b1, D_ABC);
    wait_done();
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      $display("FAIL pending_digests got=%0d want=0", sb.size());
      bad++;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
